// File: rtl/bus_mem_target.sv
// Word-addressed RAM target for the shared request/ack bus: accepts single/burst reads and writes,
// bids for the bus to return data or acks. Optional range checking via BUS_MEM_TARGET_ERR_RESP_EN.
module bus_mem_target #(
  parameter int         DEPTH    = 256,
  parameter int         ADDR_W   = 8,
  parameter logic [1:0] REQ_PRIO = 2'b11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        selin,
  input  logic [2:0]  cmdin,
  input  logic [1:0]  lenin,
  input  logic [31:0] addrdatain,
  input  logic [3:0]  srcid,
  input  logic        ackin,
  output logic [1:0]  reqout,
  output logic [1:0]  lenout,
  output logic [31:0] addrdataout,
  output logic [2:0]  cmdout,
  output logic [3:0]  reqtar,
  output logic        busy
);

  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [2:0] CMD_RREQ  = 3'b010;
  localparam logic [2:0] CMD_RDATA = 3'b011;
  localparam logic [2:0] CMD_WREQ  = 3'b100;
  localparam logic [2:0] CMD_WDATA = 3'b101;
  localparam logic [2:0] CMD_WACK  = 3'b110;
  localparam logic [2:0] CMD_ERR   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_BID,
    S_RDATA,
    S_WACK
  } state_t;

  function automatic logic [3:0] lenToBeats(input logic [1:0] code);
    return 4'd1 << code;
  endfunction

  logic [31:0]       r_mem [DEPTH];

  state_t            r_state,   w_state;
  logic [3:0]        r_beat,    w_beat;
  logic [ADDR_W-1:0] r_start,   w_start;
  logic [1:0]        r_len,     w_len;
  logic [3:0]        r_src,     w_src;
  logic              r_isRead,  w_isRead;
  logic              r_err,     w_err;
  logic [31:0]       r_addr,    w_addr;
  logic [1:0]        r_reqout,  w_reqout;
  logic [1:0]        r_lenout,  w_lenout;
  logic [31:0]       r_dataout, w_dataout;
  logic [2:0]        r_cmdout,  w_cmdout;
  logic [3:0]        r_reqtar,  w_reqtar;

  logic [3:0]        w_beats;
  logic [ADDR_W-1:0] w_reqStart;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_rdData;
  logic              w_memWe;
  logic              w_reqErr;

  assign w_beats    = lenToBeats(r_len);
  assign w_reqStart = addrdatain[ADDR_W+1:2];
  // One index serves both write beats and read beats; r_beat is 0 in BID so beat 0 is fetched on the grant edge.
  assign w_idx      = r_start + ADDR_W'(r_beat);
  assign w_rdData   = r_mem[w_idx];

`ifdef BUS_MEM_TARGET_ERR_RESP_EN
  logic [3:0] w_reqBeats;
  assign w_reqBeats = lenToBeats(lenin);
  assign w_reqErr   = (addrdatain[31:ADDR_W+2] != '0) ||
                      ((int'(w_reqStart) + int'(w_reqBeats) - 1) >= DEPTH);
`else
  assign w_reqErr   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_beat    <= '0;
      r_start   <= '0;
      r_len     <= '0;
      r_src     <= '0;
      r_isRead  <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_reqout  <= '0;
      r_lenout  <= '0;
      r_dataout <= '0;
      r_cmdout  <= CMD_IDLE;
      r_reqtar  <= '0;
    end else begin
      r_state   <= w_state;
      r_beat    <= w_beat;
      r_start   <= w_start;
      r_len     <= w_len;
      r_src     <= w_src;
      r_isRead  <= w_isRead;
      r_err     <= w_err;
      r_addr    <= w_addr;
      r_reqout  <= w_reqout;
      r_lenout  <= w_lenout;
      r_dataout <= w_dataout;
      r_cmdout  <= w_cmdout;
      r_reqtar  <= w_reqtar;
    end
  end

  // RAM is never cleared; a reset cycle blocks any write in flight.
  always_ff @(posedge clk) begin
    if (!reset && w_memWe) begin
      r_mem[w_idx] <= addrdatain;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_beat    = r_beat;
    w_start   = r_start;
    w_len     = r_len;
    w_src     = r_src;
    w_isRead  = r_isRead;
    w_err     = r_err;
    w_addr    = r_addr;
    w_reqout  = r_reqout;
    w_lenout  = r_lenout;
    w_dataout = r_dataout;
    w_cmdout  = r_cmdout;
    w_reqtar  = r_reqtar;
    w_memWe   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (selin && (cmdin == CMD_RREQ || cmdin == CMD_WREQ)) begin
          w_start  = w_reqStart;
          w_len    = lenin;
          w_src    = srcid;
          w_addr   = addrdatain;
          w_err    = w_reqErr;
          w_beat   = '0;
          w_isRead = (cmdin == CMD_RREQ);
          if (cmdin == CMD_RREQ) begin
            w_state  = S_BID;
            w_reqout = REQ_PRIO;
          end else begin
            w_state  = S_WDATA;
          end
        end
      end

      S_WDATA: begin
        if (selin && cmdin == CMD_WDATA) begin
          w_memWe = !r_err;
          w_beat  = r_beat + 4'd1;
          if (r_beat == w_beats - 4'd1) begin
            w_beat   = '0;
            w_state  = S_BID;
            w_reqout = REQ_PRIO;
          end
        end
      end

      S_BID: begin
        if (ackin) begin
          w_reqout = '0;
          w_reqtar = r_src;
          w_lenout = r_len;
          if (r_isRead) begin
            w_state = S_RDATA;
            if (r_err) begin
              // Single error beat: parking the counter at N ends the burst on the next edge.
              w_cmdout  = CMD_ERR;
              w_dataout = r_addr;
              w_lenout  = '0;
              w_beat    = w_beats;
            end else begin
              w_cmdout  = CMD_RDATA;
              w_dataout = w_rdData;
              w_beat    = 4'd1;
            end
          end else begin
            w_state   = S_WACK;
            w_cmdout  = r_err ? CMD_ERR : CMD_WACK;
            w_dataout = r_addr;
          end
        end
      end

      S_RDATA: begin
        if (r_beat == w_beats) begin
          w_state   = S_IDLE;
          w_beat    = '0;
          w_cmdout  = CMD_IDLE;
          w_dataout = '0;
          w_lenout  = '0;
          w_reqtar  = '0;
        end else begin
          w_dataout = w_rdData;
          w_beat    = r_beat + 4'd1;
        end
      end

      S_WACK: begin
        w_state   = S_IDLE;
        w_beat    = '0;
        w_cmdout  = CMD_IDLE;
        w_dataout = '0;
        w_lenout  = '0;
        w_reqtar  = '0;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign reqout      = r_reqout;
  assign lenout      = r_lenout;
  assign addrdataout = r_dataout;
  assign cmdout      = r_cmdout;
  assign reqtar      = r_reqtar;
  assign busy        = (r_state != S_IDLE);

endmodule
